instr_fetch_unit: RTL
=====================

// Module: instr_fetch_unit
// PURPOSE
//  Program-counter and fetch stage directly upstream of the text (instruction) ROM.
//  - Holds the PC and drives the ROM word address.
//  - Captures the combinational ROM read into a 2-entry skid FIFO.
//  - Presents {pc, instr} to decode over a valid/ready handshake.
//  - Takes PC redirects from branch/jump resolution; traps on misaligned targets.
// PARAMETERS
//  DATA_WIDTH  32     instruction width; must match the ROM data width
//  ADDR_WIDTH  8      ROM word-address width; imem_addr = pc[ADDR_WIDTH+1:2]
//  RESET_PC    32'h0  PC loaded at reset; must be 4-byte aligned
// PORTS
//  clk             in   1           rising-edge clock
//  rst_n           in   1           asynchronous active-low reset
//  redirect_valid  in   1           load redirect_pc this cycle, flushing the FIFO
//  redirect_pc     in   32          byte address of the new PC
//  imem_addr       out  ADDR_WIDTH  word address to the ROM (combinational from pc)
//  imem_data       in   DATA_WIDTH  ROM read data, valid in the same cycle
//  out_valid       out  1           FIFO head is valid
//  out_ready       in   1           decode accepts the head
//  out_instr       out  DATA_WIDTH  instruction at the FIFO head
//  out_pc          out  32          byte PC of out_instr
//  misalign_err    out  1           sticky; set by a misaligned redirect
// BEHAVIOUR
//  Reset values (async, rst_n=0):
//   pc=RESET_PC, state=BOOT, FIFO count=0, out_valid=0, out_instr=0, out_pc=0, misalign_err=0.
//  FSM: BOOT -> RUN on the first clk edge after reset release.
//   RUN -> TRAP on redirect_valid with redirect_pc[1:0]!=0.
//   TRAP is held until reset.
//  pop  = out_valid & out_ready.
//  push = (state==RUN) & ~redirect_valid & (count<2 | pop).
//  On push: FIFO takes {pc, imem_data}; pc <= pc+4 (mod 2^32).
//   Each fetch occupies exactly one cycle.
//  Latency: first out_valid=1 on the 2nd rising edge after rst_n deasserts,
//   with out_pc=RESET_PC.
//  Steady state: with out_ready held 1, one instruction per cycle, no bubbles.
//  FIFO full (count=2) and no pop: pc holds and no push (backpressure).
//   Full with pop: pop and push in the same cycle; count stays 2.
//  Outputs come from the FIFO head register only; no combinational path
//   from imem_data to out_*.
//  Redirect, aligned, in RUN:
//   - A pop asserted in the same cycle completes.
//   - All other entries are flushed; count=0.
//   - pc <= redirect_pc; no push that cycle.
//   - First redirected instruction is valid one edge later.
//  Redirect in BOOT: pc <= redirect_pc; the FSM still moves to RUN.
//  Misaligned redirect (redirect_pc[1:0]!=0):
//   - FIFO flushed; pc unchanged; state=TRAP.
//   - misalign_err=1 from the next edge; out_valid=0 thereafter.
//  Redirect in TRAP: ignored.
//  Address wrap: imem_addr is pc truncated to word bits, so fetches wrap
//   modulo 4*2^ADDR_WIDTH bytes. out_pc reports the full untruncated 32-bit pc.
//  rst_n asserted mid-operation: all state returns to reset values immediately;
//   in-flight entries are discarded.
//  out_instr/out_pc hold their value while out_valid=1 and out_ready=0.
// STRUCTURE
//  Shared package fetch_pkg:
//   - FETCH_FIFO_DEPTH=2.
//   - FSM state encoding {BOOT, RUN, TRAP}.
//   - INSTR_NOP=32'h00000013.
//   - Type of the {pc, instr} FIFO entry.
//  Sub-module fetch_skid_fifo:
//   - 2-entry FIFO with flush.
//   - Simultaneous push and pop when full.
//   - Registered head outputs.
//  PC register, next-PC logic and FSM live in instr_fetch_unit.
// TESTING
//  1. ROM model: word0=32'h00052503, word1=32'h0045a583; out_ready=1; release reset
//     -> edge 2: out_pc=0, out_instr=32'h00052503; edge 3: out_pc=4, out_instr=32'h0045a583.
//  2. out_ready=0 for 5 cycles after first valid
//     -> count saturates at 2; pc=8; head holds pc 0.
//     Then out_ready=1 -> pcs 0, 4, 8 appear on consecutive cycles.
//  3. redirect_valid=1, redirect_pc=32'h30 while full, same cycle as a pop
//     -> the popped entry completes; next out_pc=32'h30, out_instr=ROM word 'h0C (32'h00c6f6b3).
//  4. redirect_pc=32'h32
//     -> misalign_err=1 next edge; out_valid=0 for 10 cycles; a later aligned redirect is ignored.
//  5. redirect_pc=32'h3FC with ADDR_WIDTH=8
//     -> successive imem_addr 'hFF then 'h00; out_pc 32'h3FC then 32'h400.
//  6. Assert rst_n=0 mid-stream with count=2
//     -> out_valid=0 and misalign_err=0 immediately; after release, restarts at RESET_PC with latency 2.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared definitions for the instruction fetch stage: FIFO depth, FSM encoding
// and the {pc, instr} entry carried from the ROM to decode.
package fetch_pkg;
   localparam int          FETCH_FIFO_DEPTH = 2;
   localparam int          FETCH_INSTR_WIDTH = 32;

   localparam logic [1:0]  ST_BOOT = 2'd0;
   localparam logic [1:0]  ST_RUN  = 2'd1;
   localparam logic [1:0]  ST_TRAP = 2'd2;

   localparam logic [31:0] INSTR_NOP = 32'h0000_0013;

   typedef struct packed {
      logic [31:0]                  pc;
      logic [FETCH_INSTR_WIDTH-1:0] instr;
   } fetch_entry_t;
endpackage

// File: rtl/fetch_skid_fifo.sv
// Two-entry skid FIFO holding fetched {pc, instr} pairs; the head lives in its
// own register so downstream outputs never see the ROM combinationally.
module fetch_skid_fifo
   import fetch_pkg::*;
(
   input  logic         clk,
   input  logic         rst_n,
   input  logic         flush,
   input  logic         push,
   input  logic         pop,
   input  fetch_entry_t in_entry,
   output fetch_entry_t head,
   output logic         valid,
   output logic         full
);
   localparam logic [1:0] DEPTH = 2'(FETCH_FIFO_DEPTH);

   fetch_entry_t head_reg, head_next;
   fetch_entry_t tail_reg, tail_next;
   logic [1:0]   count_reg, count_next;

   always_comb begin
      head_next  = head_reg;
      tail_next  = tail_reg;
      count_next = count_reg;
      if (flush) begin
         count_next = 2'd0;
      end else begin
         case ({push, pop})
            2'b10: begin
               if (count_reg == 2'd0) head_next = in_entry;
               else                   tail_next = in_entry;
               count_next = count_reg + 2'd1;
            end
            2'b01: begin
               head_next  = tail_reg;
               count_next = count_reg - 2'd1;
            end
            2'b11: begin
               // Full: tail slides to head while the new fetch refills the tail.
               if (count_reg == DEPTH) begin
                  head_next = tail_reg;
                  tail_next = in_entry;
               end else begin
                  head_next = in_entry;
               end
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         head_reg  <= '0;
         tail_reg  <= '0;
         count_reg <= 2'd0;
      end else begin
         head_reg  <= head_next;
         tail_reg  <= tail_next;
         count_reg <= count_next;
      end
   end

   assign head  = head_reg;
   assign valid = (count_reg != 2'd0);
   assign full  = (count_reg == DEPTH);
endmodule

// File: rtl/instr_fetch_unit.sv
// PC register, redirect/trap FSM and ROM addressing for the fetch stage; fetched
// words are buffered in fetch_skid_fifo and handed to decode via valid/ready.
module instr_fetch_unit
   import fetch_pkg::*;
#(
   parameter int          DATA_WIDTH = 32,
   parameter int          ADDR_WIDTH = 8,
   parameter logic [31:0] RESET_PC   = 32'h0
)(
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  redirect_valid,
   input  logic [31:0]           redirect_pc,
   output logic [ADDR_WIDTH-1:0] imem_addr,
   input  logic [DATA_WIDTH-1:0] imem_data,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [DATA_WIDTH-1:0] out_instr,
   output logic [31:0]           out_pc,
   output logic                  misalign_err
);
   logic [1:0]   state_reg, state_next;
   logic [31:0]  pc_reg, pc_next;
   logic         misalign_err_reg, misalign_err_next;

   logic         redirect_live, redirect_bad;
   logic         pop, push, flush;
   logic         fifo_valid, fifo_full;
   fetch_entry_t push_entry, head_entry;

   // Redirects are dead once trapped; only reset leaves TRAP.
   assign redirect_live = redirect_valid & (state_reg != ST_TRAP);
   assign redirect_bad  = redirect_live & (redirect_pc[1:0] != 2'b00);

   assign pop   = fifo_valid & out_ready;
   assign push  = (state_reg == ST_RUN) & ~redirect_valid & (~fifo_full | pop);
   assign flush = redirect_live;

   always_comb begin
      state_next        = state_reg;
      pc_next           = pc_reg;
      misalign_err_next = misalign_err_reg;
      case (state_reg)
         ST_BOOT: state_next = redirect_bad ? ST_TRAP : ST_RUN;
         ST_RUN:  if (redirect_bad) state_next = ST_TRAP;
         default: state_next = ST_TRAP;
      endcase
      if (redirect_bad)       misalign_err_next = 1'b1;
      else if (redirect_live) pc_next = redirect_pc;
      else if (push)          pc_next = pc_reg + 32'd4;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg        <= ST_BOOT;
         pc_reg           <= RESET_PC;
         misalign_err_reg <= 1'b0;
      end else begin
         state_reg        <= state_next;
         pc_reg           <= pc_next;
         misalign_err_reg <= misalign_err_next;
      end
   end

   assign push_entry.pc    = pc_reg;
   assign push_entry.instr = imem_data;

   fetch_skid_fifo u_fifo (
      .clk      (clk),
      .rst_n    (rst_n),
      .flush    (flush),
      .push     (push),
      .pop      (pop),
      .in_entry (push_entry),
      .head     (head_entry),
      .valid    (fifo_valid),
      .full     (fifo_full)
   );

   assign imem_addr    = pc_reg[ADDR_WIDTH+1:2];
   assign out_valid    = fifo_valid;
   assign out_instr    = head_entry.instr;
   assign out_pc       = head_entry.pc;
   assign misalign_err = misalign_err_reg;
endmodule
